// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD transmitter.
package lcd_pkg;

  typedef enum logic [2:0] {
    StPwrup,
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StWait
  } lcd_state_e;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;

  // Clear and return-home need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == 8'h01) || (data == 8'h02) || (data == 8'h03));
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_tx_ctrl.sv
// HD44780-class write-only transmitter: one byte per valid/ready handshake, with
// SETUP/EN/HOLD/execution-wait sequencing and an automatic power-up init sequence.
module lcd_tx_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 1000000,
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_PULSE = 25,
  parameter int unsigned T_HOLD  = 4,
  parameter int unsigned T_SHORT = 2500,
  parameter int unsigned T_LONG  = 100000,
  parameter bit          INIT_EN = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_valid,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  output logic       o_ready,
  output logic       o_init_done,
  output logic       o_lcd_on,
  output logic       o_lcd_en,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic [7:0] o_lcd_data
);

  localparam int unsigned MaxT = max_u(max_u(max_u(T_PWRUP, T_SETUP), max_u(T_PULSE, T_HOLD)),
                                       max_u(T_SHORT, T_LONG));
  localparam int unsigned CntW = $clog2(MaxT) + 1;

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t LdPwrup = cnt_t'(T_PWRUP - 1);
  localparam cnt_t LdSetup = cnt_t'(T_SETUP - 1);
  localparam cnt_t LdPulse = cnt_t'(T_PULSE - 1);
  localparam cnt_t LdHold  = cnt_t'(T_HOLD - 1);
  localparam cnt_t LdShort = cnt_t'(T_SHORT - 1);
  localparam cnt_t LdLong  = cnt_t'(T_LONG - 1);

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    unique case (idx)
      2'd0: cmd = LCD_FUNC_SET;
      2'd1: cmd = LCD_DISP_ON;
      2'd2: cmd = LCD_CLEAR;
      2'd3: cmd = LCD_ENTRY;
    endcase
    return cmd;
  endfunction

  lcd_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic       init_done_q, init_done_d;
  logic       rs_q, rs_d;
  logic [7:0] data_q, data_d;
  logic       en_q, en_d;
  logic       on_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    rs_d        = rs_q;
    data_d      = data_q;

    case (state_q)
      // The counter resets to 0, so power-up counts up rather than down.
      StPwrup: begin
        if (cnt_q == LdPwrup) begin
          state_d = StSetup;
          cnt_d   = LdSetup;
          idx_d   = 2'd0;
          rs_d    = 1'b0;
          data_d  = init_cmd(2'd0);
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      StIdle: begin
        if (!init_done_q) begin
          init_done_d = 1'b1;
        end else if (i_valid) begin
          state_d = StSetup;
          cnt_d   = LdSetup;
          rs_d    = i_rs;
          data_d  = i_data;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StPulse;
          cnt_d   = LdPulse;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = LdHold;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StWait;
          cnt_d   = is_long_cmd(rs_q, data_q) ? LdLong : LdShort;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      StWait: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - cnt_t'(1);
        end else if (init_done_q) begin
          state_d = StIdle;
        end else if (idx_q == 2'd3) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end else begin
          state_d = StSetup;
          cnt_d   = LdSetup;
          idx_d   = idx_q + 2'd1;
          rs_d    = 1'b0;
          data_d  = init_cmd(idx_q + 2'd1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // EN is registered so the external strobe is glitch-free.
  assign en_d = (state_d == StPulse);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      if (INIT_EN) begin
        state_q <= StPwrup;
      end else begin
        state_q <= StIdle;
      end
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      init_done_q <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      en_q        <= 1'b0;
      on_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      en_q        <= en_d;
      on_q        <= 1'b1;
    end
  end

  assign o_ready     = (state_q == StIdle) && init_done_q;
  assign o_init_done = init_done_q;
  assign o_lcd_on    = on_q;
  assign o_lcd_en    = en_q;
  assign o_lcd_rs    = rs_q;
  assign o_lcd_rw    = 1'b0;
  assign o_lcd_data  = data_q;

endmodule

// File: tb/tb_lcd_tx_ctrl.sv
// Bench for lcd_tx_ctrl: per-cycle comparison against a timestamp-based transaction model,
// plus directed init, back-to-back, mid-pulse reset and INIT_EN=0 checks.
module tb_lcd_tx_ctrl;

  localparam int unsigned TPwrup = 20;
  localparam int unsigned TSetup = 2;
  localparam int unsigned TPulse = 4;
  localparam int unsigned THold  = 2;
  localparam int unsigned TShort = 10;
  localparam int unsigned TLong  = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, valid, rs;
  logic [7:0] data;
  logic       ready, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  logic       rst2_n, valid2, rs2;
  logic [7:0] data2;
  logic       ready2, init_done2, lcd_on2, lcd_en2, lcd_rs2, lcd_rw2;
  logic [7:0] lcd_data2;

  lcd_tx_ctrl #(
    .T_PWRUP(TPwrup), .T_SETUP(TSetup), .T_PULSE(TPulse), .T_HOLD(THold),
    .T_SHORT(TShort), .T_LONG(TLong), .INIT_EN(1'b1)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_valid(valid), .i_rs(rs), .i_data(data),
    .o_ready(ready), .o_init_done(init_done), .o_lcd_on(lcd_on), .o_lcd_en(lcd_en),
    .o_lcd_rs(lcd_rs), .o_lcd_rw(lcd_rw), .o_lcd_data(lcd_data)
  );

  lcd_tx_ctrl #(
    .T_PWRUP(TPwrup), .T_SETUP(TSetup), .T_PULSE(TPulse), .T_HOLD(THold),
    .T_SHORT(TShort), .T_LONG(TLong), .INIT_EN(1'b0)
  ) dut_noinit (
    .i_clk(clk), .i_reset(rst2_n), .i_valid(valid2), .i_rs(rs2), .i_data(data2),
    .o_ready(ready2), .o_init_done(init_done2), .o_lcd_on(lcd_on2), .o_lcd_en(lcd_en2),
    .o_lcd_rs(lcd_rs2), .o_lcd_rw(lcd_rw2), .o_lcd_data(lcd_data2)
  );

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    n_checks++;
    n_fails++;
    $error("FAIL %s: observed no completion, expected completion within cycle bound", tag);
  endtask

  // Model: every transaction is a start edge plus a length; outputs follow from timestamps.
  int unsigned edge_n;
  logic [7:0]  init_q[$];
  int unsigned m_next_init, m_done_edge, m_start, m_busy_until;
  bit          m_have_txn, m_rs, m_ready;
  logic [7:0]  m_data;
  int unsigned rise_edges[$];
  logic [7:0]  rise_data[$];
  int unsigned ready_rise_edge;
  logic        prev_en, prev_ready;

  function automatic int unsigned txn_len(input bit r, input logic [7:0] d);
    bit long_cmd;
    long_cmd = !r && (d == 8'h01 || d == 8'h02 || d == 8'h03);
    return TSetup + TPulse + THold + (long_cmd ? TLong : TShort);
  endfunction

  task automatic model_reset();
    edge_n       = 0;
    init_q       = '{8'h38, 8'h0C, 8'h01, 8'h06};
    m_next_init  = TPwrup;
    m_done_edge  = 32'hFFFF_FFFF;
    m_busy_until = 0;
    m_have_txn   = 0;
    m_rs         = 0;
    m_data       = 8'h00;
    m_ready      = 0;
    prev_en      = 0;
    prev_ready   = 0;
    rise_edges.delete();
    rise_data.delete();
  endtask

  task automatic start(input int unsigned k, input bit r, input logic [7:0] d);
    m_start      = k;
    m_rs         = r;
    m_data       = d;
    m_busy_until = k + txn_len(r, d);
    m_have_txn   = 1;
  endtask

  // Advance one clock edge, update the model, compare all outputs just after the edge.
  task automatic step();
    bit         v, r, exp_en;
    logic [7:0] d;
    v = valid;
    r = rs;
    d = data;
    @(posedge clk);
    #1;
    edge_n++;
    if (init_q.size() != 0 && edge_n == m_next_init) begin
      start(edge_n, 1'b0, init_q.pop_front());
      m_next_init = m_busy_until;
      if (init_q.size() == 0) m_done_edge = m_busy_until;
    end else if (m_ready && v) begin
      start(edge_n, r, d);
    end
    m_ready = (edge_n >= m_done_edge) && (edge_n >= m_busy_until);
    exp_en  = m_have_txn && (edge_n >= m_start + TSetup) && (edge_n < m_start + TSetup + TPulse);
    check("ready", ready, m_ready);
    check("init_done", init_done, edge_n >= m_done_edge);
    check("lcd_on", lcd_on, 1'b1);
    check("lcd_en", lcd_en, exp_en);
    check("lcd_rs", lcd_rs, m_rs);
    check("lcd_rw", lcd_rw, 1'b0);
    check("lcd_data", lcd_data, m_data);
    if (lcd_en && !prev_en) begin
      rise_edges.push_back(edge_n);
      rise_data.push_back(lcd_data);
    end
    if (ready && !prev_ready) ready_rise_edge = edge_n;
    prev_en    = lcd_en;
    prev_ready = ready;
  endtask

  task automatic send(input bit r, input logic [7:0] d, output int unsigned k);
    bit got;
    got   = 0;
    valid = 1'b1;
    rs    = r;
    data  = d;
    for (int i = 0; i < 300 && !got; i++) begin
      step();
      if (m_have_txn && m_start == edge_n) got = 1;
    end
    k = edge_n;
    if (!got) timeout("send_accept");
  endtask

  task automatic wait_ready(input bit noise);
    for (int i = 0; i < 400 && !m_ready; i++) begin
      if (noise) begin
        valid = 1'($urandom_range(0, 1));
        rs    = 1'($urandom_range(0, 1));
        data  = 8'($urandom_range(0, 255));
      end else begin
        valid = 1'b0;
      end
      step();
    end
    valid = 1'b0;
    if (!m_ready) timeout("wait_ready");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready, 1'b0);
    check({tag, "_init_done"}, init_done, 1'b0);
    check({tag, "_lcd_on"}, lcd_on, 1'b0);
    check({tag, "_lcd_en"}, lcd_en, 1'b0);
    check({tag, "_lcd_rs"}, lcd_rs, 1'b0);
    check({tag, "_lcd_rw"}, lcd_rw, 1'b0);
    check({tag, "_lcd_data"}, lcd_data, 8'h00);
  endtask

  task automatic release_and_init();
    logic [7:0] exp_cmds[4];
    exp_cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    wait_ready(1'b0);
    check("init_pulse_count", rise_edges.size(), 4);
    if (rise_edges.size() == 4) begin
      check("init_first_rise", rise_edges[0], TPwrup + TSetup);
      for (int i = 0; i < 4; i++) check("init_cmd", rise_data[i], exp_cmds[i]);
      check("init_gap01", rise_edges[1] - rise_edges[0], txn_len(1'b0, 8'h38));
      check("init_gap12", rise_edges[2] - rise_edges[1], txn_len(1'b0, 8'h0C));
      check("init_gap23", rise_edges[3] - rise_edges[2], TSetup + TPulse + THold + TLong);
    end
    check("init_done_with_ready", init_done, ready);
  endtask

  initial begin
    int unsigned k, k2;
    bit          r;
    logic [7:0]  d;

    rst_n  = 1'b0;
    valid  = 1'b0;
    rs     = 1'b0;
    data   = 8'h00;
    rst2_n = 1'b0;
    valid2 = 1'b0;
    rs2    = 1'b0;
    data2  = 8'h00;
    model_reset();

    #12;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    check_reset_outputs("reset_clocked");
    check("noinit_reset_ready", ready2, 1'b0);
    check("noinit_reset_done", init_done2, 1'b0);

    release_and_init();

    // Data write 0x41: EN rise sampled right after edge k+TSetup, ready after the full sequence.
    send(1'b1, 8'h41, k);
    wait_ready(1'b0);
    check("data41_rise", rise_edges[$], k + TSetup);
    check("data41_ready", ready_rise_edge, k + TSetup + TPulse + THold + TShort);

    send(1'b0, 8'h02, k);
    wait_ready(1'b0);
    check("home_ready", ready_rise_edge, k + TSetup + TPulse + THold + TLong);

    send(1'b0, 8'h80, k);
    wait_ready(1'b0);
    check("ddram_ready", ready_rise_edge, k + TSetup + TPulse + THold + TShort);

    // Valid held across two requests: second accept on the first IDLE cycle.
    send(1'b1, 8'h55, k);
    send(1'b1, 8'h66, k2);
    check("b2b_accept", k2, k + TSetup + TPulse + THold + TShort + 1);
    wait_ready(1'b0);

    for (int t = 0; t < 30; t++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) step();
      r = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom_range(0, 255));
      send(r, d, k);
      wait_ready(1'b1);
    end

    // Reset while EN is high.
    send(1'b1, 8'hA5, k);
    valid = 1'b0;
    for (int i = 0; i < TSetup; i++) step();
    check("pre_reset_en", lcd_en, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    check("reset_pulse_en", lcd_en, 1'b0);
    check_reset_outputs("reset_pulse");
    @(posedge clk);
    release_and_init();

    // INIT_EN=0 instance: ready straight after the first edge, no EN until a request.
    @(posedge clk);
    #2;
    rst2_n = 1'b1;
    step();
    check("noinit_ready", ready2, 1'b1);
    check("noinit_done", init_done2, 1'b1);
    check("noinit_on", lcd_on2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("noinit_quiet_en", lcd_en2, 1'b0);
    end
    valid2 = 1'b1;
    rs2    = 1'b1;
    data2  = 8'h33;
    step();
    valid2 = 1'b0;
    check("noinit_busy", ready2, 1'b0);
    check("noinit_data", lcd_data2, 8'h33);
    check("noinit_rs", lcd_rs2, 1'b1);
    for (int i = 1; i <= TSetup + TPulse + THold + TShort; i++) begin
      step();
      check("noinit_en", lcd_en2, (i >= TSetup) && (i < TSetup + TPulse));
      check("noinit_rw", lcd_rw2, 1'b0);
      check("noinit_ready_ret", ready2, i == TSetup + TPulse + THold + TShort);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
